// File: rtl/fetch_pkg.sv
// fetch_pkg: shared FSM state type and width helpers for the fetch/prefetch unit
package fetch_pkg;
  typedef enum logic [2:0] {IDLE, DEM_RD, DEM_WR, PREFETCH, RESP} state_t;
  function automatic int stride_f(input int dw);
    return dw / 8;
  endfunction
  function automatic int tmo_w(input int t);
    return $clog2(t + 1);
  endfunction
endpackage

// File: rtl/fetch_pf_buf.sv
// fetch_pf_buf: circular prefetch FIFO with push, pop, flush and occupancy flags
// Ports: clk, rst (async, active-high); push/din write the tail; pop advances the head;
// flush empties the buffer; head is the oldest word; count/full/empty report occupancy.
module fetch_pf_buf #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  parameter int NW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output logic [NW-1:0]     count,
  output logic              full,
  output logic              empty
);
  localparam int PW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0] rd, wr;
  assign head = mem[rd];
  assign full = count == NW'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else if (flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (push && !full) begin
        wr <= wr + 1'b1;
        count <= count + 1'b1;
      end
      if (pop && !empty) begin
        rd <= rd + 1'b1;
        count <= count - 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push && !full && !flush) mem[wr] <= din;
  end
endmodule

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: CPU load/store port to W_ bus master with sequential prefetch and bus timeout
// Ports: clk, rst (async, active-high); CPU side f_enable/write_mode/addr/data_i in,
// data_o/ack/err out; bus side W_ADDR/W_DATA_O/W_WRITE/W_REQ out, W_DATA_I/W_ACK in.
module fetch_prefetch_unit import fetch_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_enable,
  input  logic              write_mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              ack,
  output logic              err,
  output logic [ADDR_W-1:0] W_ADDR,
  output logic [DATA_W-1:0] W_DATA_O,
  input  logic [DATA_W-1:0] W_DATA_I,
  output logic              W_WRITE,
  output logic              W_REQ,
  input  logic              W_ACK
);
  localparam int STRIDE = stride_f(DATA_W);
  localparam int CW = tmo_w(TIMEOUT);
  localparam int NW = $clog2(DEPTH + 1);
  state_t state, state_n;
  logic [ADDR_W-1:0] pf_addr, iss_addr;
  logic [CW-1:0] tmo_cnt;
  logic [NW-1:0] count;
  logic [DATA_W-1:0] head;
  logic pf_stop, missed, err_r, full, empty;
  logic push, pop, flush, issue, hit, rd_miss, tmo, done;
  fetch_pf_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NW(NW)) u_buf (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush), .din(W_DATA_I),
    .head(head), .count(count), .full(full), .empty(empty)
  );
  // abort on the cycle the stall count would reach TIMEOUT, so W_REQ is high exactly TIMEOUT cycles
  assign tmo = W_REQ && !W_ACK && tmo_cnt == CW'(TIMEOUT - 1);
  assign done = W_REQ && (W_ACK || tmo);
  assign hit = f_enable && !write_mode && !empty && addr == pf_addr;
  assign rd_miss = state == IDLE && f_enable && !write_mode && !hit;
  assign iss_addr = f_enable ? addr : pf_addr + ADDR_W'(count) * ADDR_W'(STRIDE);
  assign ack = state == RESP;
  assign err = ack && err_r;
  always_comb begin
    state_n = state;
    push = 1'b0;
    pop = 1'b0;
    flush = 1'b0;
    issue = 1'b0;
    case (state)
      IDLE: begin
        if (f_enable && write_mode) begin
          state_n = DEM_WR;
          flush = 1'b1;
          issue = 1'b1;
        end else if (hit) begin
          state_n = RESP;
          pop = 1'b1;
        end else if (f_enable) begin
          state_n = DEM_RD;
          flush = 1'b1;
          issue = 1'b1;
        end else if (!full && !pf_stop && missed) begin
          state_n = PREFETCH;
          issue = 1'b1;
        end
      end
      DEM_RD, DEM_WR: state_n = done ? RESP : state;
      PREFETCH: begin
        state_n = done ? IDLE : state;
        push = W_REQ && W_ACK;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      W_REQ <= 1'b0;
      W_ADDR <= '0;
      W_WRITE <= 1'b0;
      W_DATA_O <= '0;
      tmo_cnt <= '0;
    end else begin
      if (issue) begin
        W_REQ <= 1'b1;
        W_ADDR <= iss_addr;
        W_WRITE <= f_enable && write_mode;
        W_DATA_O <= f_enable && write_mode ? data_i : '0;
      end else if (done) W_REQ <= 1'b0;
      tmo_cnt <= (issue || !W_REQ || W_ACK) ? '0 : tmo_cnt + CW'(1);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_o <= '0;
      pf_addr <= '0;
      pf_stop <= 1'b0;
      missed <= 1'b0;
      err_r <= 1'b0;
    end else begin
      if (pop) begin
        data_o <= head;
        pf_addr <= pf_addr + ADDR_W'(STRIDE);
      end else if (state == DEM_RD && W_REQ && W_ACK) begin
        data_o <= W_DATA_I;
        pf_addr <= W_ADDR + ADDR_W'(STRIDE);
      end
      pf_stop <= rd_miss ? 1'b0 : pf_stop | (state == PREFETCH && tmo);
      missed <= missed | rd_miss;
      err_r <= state == RESP ? 1'b0 : err_r | ((state == DEM_RD || state == DEM_WR) && tmo);
    end
  end
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb_fetch_prefetch_unit: directed self-checking bench for fetch_prefetch_unit
module tb_fetch_prefetch_unit;
  logic clk = 0, rst = 1;
  logic f_enable = 0, write_mode = 0;
  logic [31:0] addr = 0, data_i = 0, data_o, W_ADDR, W_DATA_O, W_DATA_I = 0;
  logic ack, err, W_WRITE, W_REQ, W_ACK = 0;
  int checks = 0, errors = 0;
  logic hang = 0;
  int wcnt = 0, wr_cnt = 0;
  logic [31:0] wr_addr = 0, wr_data = 0;
  logic [31:0] rd_log [$];
  localparam int LAT = 3;

  fetch_prefetch_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .f_enable(f_enable), .write_mode(write_mode), .addr(addr),
    .data_i(data_i), .data_o(data_o), .ack(ack), .err(err), .W_ADDR(W_ADDR),
    .W_DATA_O(W_DATA_O), .W_DATA_I(W_DATA_I), .W_WRITE(W_WRITE), .W_REQ(W_REQ), .W_ACK(W_ACK)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fdata(input logic [31:0] a);
    return 32'hA5A50000 + ((a - 32'h100) >> 2) + 32'd1;
  endfunction

  function automatic logic [31:0] log_at(input int n);
    return rd_log.size() > n ? rd_log[n] : 32'hFFFFFFFF;
  endfunction

  // bus slave: acks LAT negedges after seeing W_REQ unless hang is set
  always @(negedge clk) begin
    if (rst) begin
      W_ACK = 0;
      wcnt = 0;
    end else if (W_ACK) begin
      W_ACK = 0;
      wcnt = 0;
    end else if (W_REQ && !hang) begin
      wcnt++;
      if (wcnt == LAT) begin
        W_ACK = 1;
        W_DATA_I = fdata(W_ADDR);
        if (W_WRITE) begin
          wr_addr = W_ADDR;
          wr_data = W_DATA_O;
          wr_cnt++;
        end else rd_log.push_back(W_ADDR);
      end
    end else wcnt = 0;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cpu_req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] q, output logic e, output int lat, output logic req_seen);
    @(negedge clk);
    f_enable = 1;
    write_mode = wr;
    addr = a;
    data_i = d;
    lat = 0;
    q = 'x;
    e = 0;
    req_seen = W_REQ;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (ack) begin
        lat = i;
        q = data_o;
        e = err;
        break;
      end
      req_seen = req_seen | W_REQ;
    end
    f_enable = 0;
    write_mode = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle(3);
    checks++;
    if ({W_REQ, ack, err, W_WRITE} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctl: got req/ack/err/wr=%b expected 0000", {W_REQ, ack, err, W_WRITE});
    end
    checks++;
    if (data_o !== 0 || W_ADDR !== 0 || W_DATA_O !== 0) begin
      errors++;
      $display("FAIL reset_data: got data_o=%h W_ADDR=%h W_DATA_O=%h expected 0", data_o, W_ADDR, W_DATA_O);
    end
    rst = 0;
    idle(10);
    checks++;
    if (rd_log.size() !== 0) begin
      errors++;
      $display("FAIL no_pf_before_miss: got %0d bus reads expected 0", rd_log.size());
    end
  endtask

  task automatic test_read_miss();
    logic [31:0] q; logic e, rs; int lat;
    cpu_req(0, 32'h100, 0, q, e, lat, rs);
    checks++;
    if (lat !== 4 || q !== 32'hA5A50001 || e !== 0) begin
      errors++;
      $display("FAIL miss_0x100: got lat=%0d data=%h err=%b expected 4 a5a50001 0", lat, q, e);
    end
    idle(60);
    checks++;
    if (rd_log.size() !== 5 || log_at(0) !== 32'h100 || log_at(1) !== 32'h104 || log_at(2) !== 32'h108 ||
        log_at(3) !== 32'h10C || log_at(4) !== 32'h110) begin
      errors++;
      $display("FAIL prefetch_fill: got n=%0d %h %h %h %h %h expected 5 100 104 108 10c 110",
               rd_log.size(), log_at(0), log_at(1), log_at(2), log_at(3), log_at(4));
    end
    checks++;
    if (W_REQ !== 0) begin
      errors++;
      $display("FAIL full_no_req: got W_REQ=%b expected 0", W_REQ);
    end
  endtask

  task automatic test_hit_stream();
    logic [31:0] q; logic e, rs; int lat;
    logic [31:0] exp_d [4] = '{32'hA5A50002, 32'hA5A50003, 32'hA5A50004, 32'hA5A50005};
    for (int k = 0; k < 4; k++) begin
      cpu_req(0, 32'h104 + 32'(k * 4), 0, q, e, lat, rs);
      checks++;
      if (lat !== 1 || q !== exp_d[k] || e !== 0 || rs !== 0) begin
        errors++;
        $display("FAIL hit_%0d: got lat=%0d data=%h err=%b req=%b expected 1 %h 0 0", k, lat, q, e, rs, exp_d[k]);
      end
    end
    idle(60);
    checks++;
    if (rd_log.size() !== 9 || log_at(5) !== 32'h114 || log_at(8) !== 32'h120) begin
      errors++;
      $display("FAIL refill: got n=%0d first=%h last=%h expected 9 114 120", rd_log.size(), log_at(5), log_at(8));
    end
  endtask

  task automatic test_non_sequential();
    logic [31:0] q; logic e, rs; int lat, n;
    n = rd_log.size();
    cpu_req(0, 32'h200, 0, q, e, lat, rs);
    checks++;
    if (lat !== 4 || q !== 32'hA5A50041 || e !== 0 || log_at(n) !== 32'h200) begin
      errors++;
      $display("FAIL nonseq_0x200: got lat=%0d data=%h err=%b bus=%h expected 4 a5a50041 0 200", lat, q, e, log_at(n));
    end
    idle(60);
    checks++;
    if (rd_log.size() !== n + 5 || log_at(n + 1) !== 32'h204) begin
      errors++;
      $display("FAIL nonseq_pf: got n=%0d next=%h expected %0d 204", rd_log.size(), log_at(n + 1), n + 5);
    end
  endtask

  task automatic test_write_coherence();
    logic [31:0] q; logic e, rs; int lat, n, w;
    w = wr_cnt;
    cpu_req(1, 32'h104, 32'h00001234, q, e, lat, rs);
    checks++;
    if (lat == 0 || e !== 0 || wr_cnt !== w + 1 || wr_addr !== 32'h104 || wr_data !== 32'h00001234) begin
      errors++;
      $display("FAIL write_0x104: got lat=%0d err=%b writes=%0d addr=%h data=%h expected >0 0 %0d 104 00001234",
               lat, e, wr_cnt - w, wr_addr, wr_data, 1);
    end
    n = rd_log.size();
    cpu_req(0, 32'h108, 0, q, e, lat, rs);
    checks++;
    if (lat == 0 || q !== 32'hA5A50003 || e !== 0 || log_at(n) !== 32'h108) begin
      errors++;
      $display("FAIL read_after_write: got lat=%0d data=%h err=%b bus=%h expected >0 a5a50003 0 108", lat, q, e, log_at(n));
    end
    idle(60);
    w = wr_cnt;
    cpu_req(1, 32'h10C, 32'hCAFE0000, q, e, lat, rs);
    n = rd_log.size();
    cpu_req(0, 32'h10C, 0, q, e, lat, rs);
    checks++;
    if (wr_cnt !== w + 1 || q !== 32'hA5A50004 || log_at(n) !== 32'h10C) begin
      errors++;
      $display("FAIL flush_on_write: got writes=%0d data=%h bus=%h expected 1 a5a50004 10c", wr_cnt - w, q, log_at(n));
    end
  endtask

  task automatic test_timeout();
    logic [31:0] q; logic e, rs, ok, prev; int hi, rises, acks, n, lat;
    idle(60);
    hang = 1;
    @(negedge clk);
    f_enable = 1;
    addr = 32'h300;
    hi = 0; ok = 0; prev = 0; e = 0; q = 'x; rs = 'x;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ack) begin
        ok = 1;
        e = err;
        q = data_o;
        rs = W_REQ;
        break;
      end
      hi += W_REQ ? 1 : 0;
      prev = W_REQ;
    end
    f_enable = 0;
    checks++;
    if (ok !== 1 || hi !== 8 || prev !== 1 || rs !== 0 || e !== 1) begin
      errors++;
      $display("FAIL demand_timeout: got ack=%b req_cycles=%0d req_before=%b req_at_ack=%b err=%b expected 1 8 1 0 1",
               ok, hi, prev, rs, e);
    end
    checks++;
    if (q !== 32'hA5A50004) begin
      errors++;
      $display("FAIL timeout_data_kept: got %h expected a5a50004", q);
    end
    rises = 0; acks = 0; prev = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      rises += (W_REQ && !prev) ? 1 : 0;
      acks += (ack || err) ? 1 : 0;
      prev = W_REQ;
    end
    checks++;
    if (rises !== 1 || acks !== 0 || W_REQ !== 0) begin
      errors++;
      $display("FAIL pf_timeout: got req_starts=%0d ack_or_err=%0d W_REQ=%b expected 1 0 0", rises, acks, W_REQ);
    end
    hang = 0;
    n = rd_log.size();
    cpu_req(0, 32'h400, 0, q, e, lat, rs);
    checks++;
    if (q !== 32'hA5A500C1 || e !== 0 || log_at(n) !== 32'h400) begin
      errors++;
      $display("FAIL miss_after_stop: got data=%h err=%b bus=%h expected a5a500c1 0 400", q, e, log_at(n));
    end
    idle(60);
    checks++;
    if (log_at(n + 1) !== 32'h404) begin
      errors++;
      $display("FAIL pf_resume: got %h expected 404", log_at(n + 1));
    end
  endtask

  task automatic test_reset_mid_transfer();
    logic [31:0] q; logic e, rs, seen; int lat, n;
    idle(60);
    hang = 1;
    @(negedge clk);
    f_enable = 1;
    addr = 32'h500;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = W_REQ;
    end
    rst = 1;
    #1;
    checks++;
    if (seen !== 1 || W_REQ !== 0 || ack !== 0 || err !== 0) begin
      errors++;
      $display("FAIL async_reset: got req_before=%b W_REQ=%b ack=%b err=%b expected 1 0 0 0", seen, W_REQ, ack, err);
    end
    f_enable = 0;
    hang = 0;
    @(negedge clk);
    rst = 0;
    idle(10);
    n = rd_log.size();
    cpu_req(0, 32'h504, 0, q, e, lat, rs);
    checks++;
    if (lat !== 4 || q !== 32'hA5A50102 || log_at(n) !== 32'h504 || rd_log.size() !== n + 1) begin
      errors++;
      $display("FAIL miss_after_reset: got lat=%0d data=%h bus=%h n=%0d expected 4 a5a50102 504 %0d",
               lat, q, log_at(n), rd_log.size(), n + 1);
    end
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_hit_stream();
    test_non_sequential();
    test_write_coherence();
    test_timeout();
    test_reset_mid_transfer();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
Parametrised single-clock successor to the CPU fetch path. Bridges the CPU's load/store request port to the shared W_ bus as a bus master, and supports reads and writes. A small sequential prefetch buffer serves consecutive reads in one cycle. A bus timeout reports an error to the CPU so a stalled transfer cannot hang it.

Parameters:
ADDR_W, 32, address width (CPU and bus)
DATA_W, 32, data width; address stride STRIDE = DATA_W/8
DEPTH, 4, prefetch buffer entries (power of 2, >=2)
TIMEOUT, 255, max cycles W_REQ may stay high without W_ACK (>=2)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
f_enable  in  1  CPU request strobe; held high until ack
write_mode  in  1  1 = write, 0 = read; stable while f_enable high
addr  in  ADDR_W  request address
data_i  in  DATA_W  write data
data_o  out  DATA_W  read data; valid with ack, held until next read ack
ack  out  1  one-cycle completion pulse
err  out  1  high with ack when the demand transfer timed out
W_ADDR  out  ADDR_W  bus address
W_DATA_O  out  DATA_W  bus write data
W_DATA_I  in  DATA_W  bus read data, sampled when W_ACK high
W_WRITE  out  1  bus direction
W_REQ  out  1  bus request
W_ACK  in  1  bus completion

Behaviour:
- Reset: all outputs 0. FSM in IDLE. Buffer empty. pf_addr = 0. Timeout counter = 0. pf_stop = 0. Reset applies immediately in any state; an in-flight bus transfer is abandoned and W_REQ drops asynchronously.
- Bus protocol: W_REQ, W_ADDR, W_WRITE and W_DATA_O are registered and held stable until W_ACK is sampled high. The transfer completes in that cycle. W_REQ is low for at least one cycle between transfers.
- Timeout: the counter increments each cycle W_REQ=1 and W_ACK=0, and clears on W_ACK or a new transfer. When it reaches TIMEOUT the transfer is aborted: W_REQ goes low in the next cycle.
- FSM states: IDLE, DEM_RD, DEM_WR, PREFETCH, RESP.
- IDLE: f_enable is sampled only in IDLE and never in the ack cycle.
  - Read hit (buffer non-empty and addr == pf_addr): pop head into data_o, pf_addr += STRIDE, go to RESP. ack is high in the next cycle (1-cycle latency).
  - Read miss: flush buffer, clear pf_stop, go to DEM_RD, issue the bus read of addr.
  - Write: flush buffer, go to DEM_WR, issue the bus write (W_WRITE=1, W_DATA_O=data_i).
  - No request, buffer not full, pf_stop=0, and a demand miss has occurred since reset: go to PREFETCH and issue a bus read of pf_addr + count*STRIDE.
- DEM_RD: on W_ACK, data_o <= W_DATA_I, pf_addr <= addr + STRIDE, go to RESP. On timeout, err=1, data_o unchanged, go to RESP.
- DEM_WR: on W_ACK go to RESP. On timeout set err, go to RESP.
- PREFETCH: on W_ACK push W_DATA_I and go to IDLE. On timeout set pf_stop=1 (no err) and go to IDLE. A CPU request arriving during PREFETCH waits; the in-flight prefetch always completes first, then the request is evaluated in IDLE, so it may hit on the just-fetched word.
- RESP: ack=1 (and err if set) for exactly one cycle, then go to IDLE and clear err.
- Full: no prefetch is issued while count == DEPTH.
- Empty: any read is a miss.
- Address arithmetic wraps modulo 2^ADDR_W. The buffer is circular with head/tail pointers of log2(DEPTH) bits plus count.
- Simultaneous push and pop cannot occur, because the FSM serialises them.

Decomposition:
- Package fetch_pkg: state enum, STRIDE localparam function, and a timeout counter width function (clog2(TIMEOUT+1)).
- Sub-module fetch_pf_buf: circular FIFO with push, pop, flush, count, full and empty. The FSM, timeout counter and bus registers stay in the top level.

Test Plan:
- Read miss: read 0x100, W_ACK 3 cycles after W_REQ with W_DATA_I=0xA5A50001 -> ack one cycle after W_ACK, data_o=0xA5A50001, err=0. Prefetch reads of 0x104, 0x108, 0x10C and 0x110 follow, then W_REQ stays low (full).
- Hit stream: after the miss above, reads of 0x104..0x110 -> each ack one cycle after the f_enable sample, with no W_REQ during the hit cycles and data matching the prefetched words. Refill resumes at 0x114.
- Non-sequential read: 0x200 with buffer full -> flush, bus read of 0x200, ack with bus data, prefetch from 0x204.
- Write coherence: write 0x104 data 0x00001234 -> W_WRITE=1, W_DATA_O=0x00001234, ack after W_ACK. The buffer is flushed, so a following read of 0x108 goes to the bus.
- Timeout: TIMEOUT=8, W_ACK held low on a demand read -> W_REQ high for 8 cycles then low, ack=err=1 one cycle later. A timed-out prefetch gives no err and no further prefetch until the next miss.
- Reset mid-transfer: assert rst while W_REQ=1 in DEM_RD -> W_REQ, ack and err are 0 immediately. After release, the first read is a miss.
